axi_ad7124_up_bridge: RTL and testbench

AXI4-Lite slave that converts AXI register accesses into single-word transactions on the internal `up_*` register bus, acting as the initiator for the AD7124 core register responders. It sits between the processor interconnect and the `up_*` register blocks of `axi_ad7124_v2`. It serialises reads and writes, with one transaction outstanding at a time. Every transaction is bounded by an ack timeout, so a silent responder cannot hang the AXI bus.

---
 rtl/axi_ad7124_pkg.sv | 19 +
 rtl/axi_ad7124_up_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_axi_ad7124_up_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ad7124_pkg.sv
// Shared types and constants for the AD7124 AXI-Lite to up_* register bridge.
package axi_ad7124_pkg;

   // Bridge sequencer states: one transaction outstanding at a time
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_WAIT,
      ST_WR_RESP,
      ST_RD_WAIT,
      ST_RD_RESP
   } state_t;

   localparam logic [1:0]  RESP_OKAY     = 2'b00;
   localparam logic [1:0]  RESP_SLVERR   = 2'b10;

   // Read data returned when a responder never acknowledges
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/axi_ad7124_up_bridge.sv
// AXI4-Lite slave that turns register accesses into single-word up_* bus
// transactions. Reads and writes are serialised; each wait for an ack is
// bounded so a silent responder returns SLVERR instead of hanging the bus.
module axi_ad7124_up_bridge
   import axi_ad7124_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        up_clk,
   input  logic        up_rstn,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [15:0] s_axi_awaddr,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   output logic [1:0]  s_axi_bresp,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [15:0] s_axi_araddr,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        up_wreq,
   output logic [13:0] up_waddr,
   output logic [31:0] up_wdata,
   input  logic        up_wack,
   output logic        up_rreq,
   output logic [13:0] up_raddr,
   input  logic [31:0] up_rdata,
   input  logic        up_rack
);

   localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            r_state;
   state_t            w_state_next;
   logic              r_aw_full, r_w_full, r_ar_full;
   logic [13:0]       r_aw_addr, r_ar_addr;
   logic [31:0]       r_w_data;
   logic              r_last_wr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_wreq, r_rreq;
   logic [13:0]       r_waddr, r_raddr;
   logic [31:0]       r_wdata, r_rdata;
   logic [1:0]        r_bresp, r_rresp;

   logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
   logic w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd, w_timeout;
   logic w_unused;

   // Write strobes and byte-offset address bits carry no meaning on the word bus
   assign w_unused = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Readys are gated by the reset input so they read 0 for the whole reset window
   assign s_axi_awready = up_rstn & ~r_aw_full;
   assign s_axi_wready  = up_rstn & ~r_w_full;
   assign s_axi_arready = up_rstn & ~r_ar_full;

   assign w_aw_hs   = s_axi_awvalid & s_axi_awready;
   assign w_w_hs    = s_axi_wvalid  & s_axi_wready;
   assign w_ar_hs   = s_axi_arvalid & s_axi_arready;
   assign w_b_hs    = (r_state == ST_WR_RESP) & s_axi_bready;
   assign w_r_hs    = (r_state == ST_RD_RESP) & s_axi_rready;
   assign w_wr_elig = r_aw_full & r_w_full;
   assign w_rd_elig = r_ar_full;
   assign w_timeout = (r_cnt == CNT_MAX);

   assign s_axi_bvalid = (r_state == ST_WR_RESP);
   assign s_axi_rvalid = (r_state == ST_RD_RESP);
   assign s_axi_bresp  = r_bresp;
   assign s_axi_rresp  = r_rresp;
   assign s_axi_rdata  = r_rdata;
   assign up_wreq      = r_wreq;
   assign up_rreq      = r_rreq;
   assign up_waddr     = r_waddr;
   assign up_wdata     = r_wdata;
   assign up_raddr     = r_raddr;

   // One-entry holding registers, freed only by the matching B/R handshake
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_ar_full <= 1'b0;
         r_aw_addr <= '0;
         r_ar_addr <= '0;
         r_w_data  <= '0;
      end else begin
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= s_axi_awaddr[15:2];
         end else if (w_b_hs) begin
            r_aw_full <= 1'b0;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= s_axi_wdata;
         end else if (w_b_hs) begin
            r_w_full <= 1'b0;
         end
         if (w_ar_hs) begin
            r_ar_full <= 1'b1;
            r_ar_addr <= s_axi_araddr[15:2];
         end else if (w_r_hs) begin
            r_ar_full <= 1'b0;
         end
      end
   end

   // State register and last-served flag (READ after reset so a write wins first)
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_state   <= ST_IDLE;
         r_last_wr <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_b_hs) begin
            r_last_wr <= 1'b1;
         end else if (w_r_hs) begin
            r_last_wr <= 1'b0;
         end
      end
   end

   // Next state and grant; on a tie the type not served last goes first
   always_comb begin
      w_state_next = r_state;
      w_grant_wr   = 1'b0;
      w_grant_rd   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_elig && (!w_rd_elig || !r_last_wr)) begin
               w_state_next = ST_WR_WAIT;
               w_grant_wr   = 1'b1;
            end else if (w_rd_elig) begin
               w_state_next = ST_RD_WAIT;
               w_grant_rd   = 1'b1;
            end
         end
         ST_WR_WAIT: if (up_wack || w_timeout) w_state_next = ST_WR_RESP;
         ST_WR_RESP: if (s_axi_bready)         w_state_next = ST_IDLE;
         ST_RD_WAIT: if (up_rack || w_timeout) w_state_next = ST_RD_RESP;
         ST_RD_RESP: if (s_axi_rready)         w_state_next = ST_IDLE;
         default:                              w_state_next = ST_IDLE;
      endcase
   end

   // Timeout counter: cleared on grant, counts WAIT cycles, saturates at the limit
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_cnt <= '0;
      end else if (w_grant_wr || w_grant_rd) begin
         r_cnt <= '0;
      end else if ((r_state == ST_WR_WAIT || r_state == ST_RD_WAIT) && !w_timeout) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // Registered up_* request pulse plus address/data held until the next grant
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_wreq  <= 1'b0;
         r_rreq  <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_raddr <= '0;
      end else begin
         r_wreq <= w_grant_wr;
         r_rreq <= w_grant_rd;
         if (w_grant_wr) begin
            r_waddr <= r_aw_addr;
            r_wdata <= r_w_data;
         end
         if (w_grant_rd) begin
            r_raddr <= r_ar_addr;
         end
      end
   end

   // Response capture; an ack takes priority over a timeout in the same cycle
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_bresp <= RESP_OKAY;
         r_rresp <= RESP_OKAY;
         r_rdata <= '0;
      end else begin
         case (r_state)
            ST_WR_WAIT: begin
               if (up_wack) begin
                  r_bresp <= RESP_OKAY;
               end else if (w_timeout) begin
                  r_bresp <= RESP_SLVERR;
               end
            end
            ST_RD_WAIT: begin
               if (up_rack) begin
                  r_rdata <= up_rdata;
                  r_rresp <= RESP_OKAY;
               end else if (w_timeout) begin
                  r_rdata <= TIMEOUT_RDATA;
                  r_rresp <= RESP_SLVERR;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_ad7124_up_bridge.sv
// Directed bench for axi_ad7124_up_bridge: table of single transactions plus
// hand-written arbitration, late-ack and reset-abort sequences.
module tb_axi_ad7124_up_bridge;

   localparam int TMO = 8;

   logic        up_clk = 1'b0;
   logic        up_rstn = 1'b1;
   logic        s_axi_awvalid, s_axi_awready;
   logic [15:0] s_axi_awaddr;
   logic        s_axi_wvalid, s_axi_wready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_bvalid, s_axi_bready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_arvalid, s_axi_arready;
   logic [15:0] s_axi_araddr;
   logic        s_axi_rvalid, s_axi_rready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        up_wreq, up_rreq, up_wack, up_rack;
   logic [13:0] up_waddr, up_raddr;
   logic [31:0] up_wdata, up_rdata;

   // Responder behaviour: 0 = same-cycle ack, 1 = ack one cycle later, 2 = never
   int   ack_mode = 1;
   logic force_rack = 1'b0;
   logic r_wack_d = 1'b0;
   logic r_rack_d = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   int          t_acc, t_aux, t_req, t_resp, req_cnt;
   logic [13:0] cap_addr;
   logic [31:0] cap_data, res_data;
   logic [1:0]  res_resp;
   bit          stable_ok, ready_low_ok;
   logic        post_ready, post_valid;

   typedef struct {
      bit          is_wr;
      logic [15:0] addr;
      logic [31:0] data;
      int          ack;
      int          lead;
      logic [13:0] exp_addr;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs[7];

   axi_ad7124_up_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .up_clk(up_clk), .up_rstn(up_rstn),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
   );

   always #5 up_clk = ~up_clk;

   always @(posedge up_clk) begin
      cyc      <= cyc + 1;
      r_wack_d <= up_wreq;
      r_rack_d <= up_rreq;
   end

   always_comb begin
      up_wack = 1'b0;
      up_rack = 1'b0;
      case (ack_mode)
         0: begin up_wack = up_wreq;  up_rack = up_rreq;  end
         1: begin up_wack = r_wack_d; up_rack = r_rack_d; end
         default: ;
      endcase
      if (force_rack) up_rack = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input int lead);
      int guard;
      bit aw_done, w_done;
      req_cnt = 0; t_req = -1; t_resp = -1; t_acc = -1; t_aux = -1;
      cap_addr = '0; cap_data = '0; res_resp = 2'bxx;
      aw_done = 0; w_done = 0; guard = 0;
      @(negedge up_clk);
      s_axi_bready = 1'b1;
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = d;
      if (lead == 0) begin s_axi_awvalid = 1'b1; s_axi_awaddr = a; end
      while (guard < 100) begin
         if (s_axi_awvalid && s_axi_awready) begin aw_done = 1; t_acc = cyc; end
         if (s_axi_wvalid && s_axi_wready) begin w_done = 1; t_aux = cyc; end
         if (up_wreq) begin req_cnt++; t_req = cyc; cap_addr = up_waddr; cap_data = up_wdata; end
         if (s_axi_bvalid) begin t_resp = cyc; res_resp = s_axi_bresp; break; end
         @(negedge up_clk);
         guard++;
         if (aw_done) s_axi_awvalid = 1'b0;
         if (w_done)  s_axi_wvalid  = 1'b0;
         if (!aw_done && guard >= lead) begin s_axi_awvalid = 1'b1; s_axi_awaddr = a; end
      end
      @(negedge up_clk);
      s_axi_bready = 1'b0;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      post_ready = s_axi_awready & s_axi_wready;
      post_valid = s_axi_bvalid;
      $display("txn WR addr=%h data=%h up_waddr=%h resp=%b lat=%0d", a, d, cap_addr, res_resp, t_resp - t_acc);
   endtask

   task automatic axi_read(input logic [15:0] a, input int hold);
      int guard;
      bit ar_done;
      req_cnt = 0; t_req = -1; t_resp = -1; t_acc = -1;
      cap_addr = '0; res_data = '0; res_resp = 2'bxx;
      stable_ok = 1; ready_low_ok = 1; ar_done = 0; guard = 0;
      @(negedge up_clk);
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = a;
      s_axi_rready  = (hold == 0);
      while (guard < 100) begin
         if (s_axi_arvalid && s_axi_arready) begin ar_done = 1; t_acc = cyc; end
         if (ar_done && !s_axi_arvalid && s_axi_arready) ready_low_ok = 0;
         if (up_rreq) begin req_cnt++; t_req = cyc; cap_addr = up_raddr; end
         if (s_axi_rvalid) begin t_resp = cyc; res_resp = s_axi_rresp; res_data = s_axi_rdata; break; end
         @(negedge up_clk);
         guard++;
         if (ar_done) s_axi_arvalid = 1'b0;
      end
      s_axi_arvalid = 1'b0;
      for (int k = 0; k < hold; k++) begin
         @(negedge up_clk);
         if (!s_axi_rvalid || s_axi_rdata !== res_data || s_axi_rresp !== res_resp) stable_ok = 0;
         if (s_axi_arready) ready_low_ok = 0;
         if (k == hold - 1) s_axi_rready = 1'b1;
      end
      @(negedge up_clk);
      s_axi_rready = 1'b0;
      post_ready = s_axi_arready;
      post_valid = s_axi_rvalid;
      $display("txn RD addr=%h up_raddr=%h rdata=%h resp=%b lat=%0d", a, cap_addr, res_data, res_resp, t_resp - t_acc);
   endtask

   // AW+W and AR all offered in the same cycle; reports which request came first
   task automatic contend(output int first_wr, output int n_req);
      int guard, nb, nr;
      bit aw_d, w_d, ar_d;
      first_wr = -1; n_req = 0; nb = 0; nr = 0; guard = 0;
      aw_d = 0; w_d = 0; ar_d = 0;
      @(negedge up_clk);
      s_axi_awvalid = 1'b1; s_axi_awaddr = 16'h0010;
      s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h0000_0F0F;
      s_axi_arvalid = 1'b1; s_axi_araddr = 16'h0014;
      s_axi_bready  = 1'b1; s_axi_rready = 1'b1;
      while (guard < 100) begin
         if (s_axi_awvalid && s_axi_awready) aw_d = 1;
         if (s_axi_wvalid && s_axi_wready)   w_d  = 1;
         if (s_axi_arvalid && s_axi_arready) ar_d = 1;
         if (up_wreq) begin if (n_req == 0) first_wr = 1; n_req++; end
         if (up_rreq) begin if (n_req == 0) first_wr = 0; n_req++; end
         if (s_axi_bvalid) nb++;
         if (s_axi_rvalid) nr++;
         if (nb > 0 && nr > 0) break;
         @(negedge up_clk);
         guard++;
         if (aw_d) s_axi_awvalid = 1'b0;
         if (w_d)  s_axi_wvalid  = 1'b0;
         if (ar_d) s_axi_arvalid = 1'b0;
      end
      @(negedge up_clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      $display("txn CONTEND first=%s requests=%0d", (first_wr == 1) ? "WR" : "RD", n_req);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int fw, nq, guard, seen;

      //          wr  addr      data          ack lead exp_addr  resp    exp_rdata     lat
      vecs[0] = '{1, 16'h0008, 32'hCAFEF00D, 1, 0, 14'h0002, 2'b00, 32'h0,        4};
      vecs[1] = '{1, 16'h0044, 32'h0BADBEEF, 1, 3, 14'h0011, 2'b00, 32'h0,        4};
      vecs[2] = '{0, 16'h0040, 32'h00000001, 1, 5, 14'h0010, 2'b00, 32'h00000001, 4};
      vecs[3] = '{1, 16'hFFFF, 32'h12345678, 0, 0, 14'h3FFF, 2'b00, 32'h0,        3};
      vecs[4] = '{0, 16'h0003, 32'hA5A5C3C3, 0, 0, 14'h0000, 2'b00, 32'hA5A5C3C3, 3};
      vecs[5] = '{1, 16'h1234, 32'h55AA55AA, 2, 0, 14'h048D, 2'b10, 32'h0,        11};
      vecs[6] = '{0, 16'h8000, 32'h01234567, 2, 2, 14'h2000, 2'b10, 32'hDEADDEAD, 11};

      s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_wvalid = 0; s_axi_wdata = '0;
      s_axi_wstrb = 4'hF; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = '0;
      s_axi_rready = 0; up_rdata = '0;

      // Reset state
      #2 up_rstn = 1'b0;
      #1;
      chk("rst_awready", 32'(s_axi_awready), 32'd0);
      chk("rst_wready",  32'(s_axi_wready),  32'd0);
      chk("rst_arready", 32'(s_axi_arready), 32'd0);
      chk("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
      chk("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
      chk("rst_reqs",    32'({up_wreq, up_rreq}), 32'd0);
      repeat (3) @(negedge up_clk);
      up_rstn = 1'b1;
      @(negedge up_clk);
      chk("post_rst_readys", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

      // Arbitration straight after reset: write wins the first tie
      ack_mode = 1;
      contend(fw, nq);
      chk("arb1_first_is_write", 32'(fw), 32'd1);
      chk("arb1_req_count", 32'(nq), 32'd2);

      // Table-driven single transactions
      for (int i = 0; i < 7; i++) begin
         ack_mode = vecs[i].ack;
         up_rdata = vecs[i].data;
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].lead);
            chk($sformatf("v%0d_wreq_count", i), 32'(req_cnt), 32'd1);
            chk($sformatf("v%0d_waddr", i), 32'(cap_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_wdata", i), cap_data, vecs[i].data);
            chk($sformatf("v%0d_w_before_aw", i), 32'(t_acc - t_aux), 32'(vecs[i].lead));
         end else begin
            axi_read(vecs[i].addr, vecs[i].lead);
            chk($sformatf("v%0d_rreq_count", i), 32'(req_cnt), 32'd1);
            chk($sformatf("v%0d_raddr", i), 32'(cap_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_rdata", i), res_data, vecs[i].exp_rdata);
            chk($sformatf("v%0d_r_stable", i), 32'(stable_ok), 32'd1);
            chk($sformatf("v%0d_arready_low", i), 32'(ready_low_ok), 32'd1);
         end
         chk($sformatf("v%0d_resp", i), 32'(res_resp), 32'(vecs[i].exp_resp));
         chk($sformatf("v%0d_req_delay", i), 32'(t_req - t_acc), 32'd2);
         chk($sformatf("v%0d_latency", i), 32'(t_resp - t_acc), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d_ready_after", i), 32'(post_ready), 32'd1);
         chk($sformatf("v%0d_valid_after", i), 32'(post_valid), 32'd0);
      end

      // A late read ack arriving while idle must be ignored
      up_rdata = 32'h1111_1111;
      seen = 0;
      @(negedge up_clk);
      force_rack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge up_clk);
         if (s_axi_rvalid || up_rreq || !s_axi_arready) seen++;
      end
      force_rack = 1'b0;
      chk("late_rack_ignored", 32'(seen), 32'd0);
      ack_mode = 1;
      up_rdata = 32'h2222_2222;
      axi_read(16'h0020, 0);
      chk("after_late_rdata", res_data, 32'h2222_2222);
      chk("after_late_rresp", 32'(res_resp), 32'd0);

      // Last served is READ: a lone write, then a tie that the read must win
      axi_write(16'h0100, 32'h0000_ABCD, 0);
      chk("lone_write_resp", 32'(res_resp), 32'd0);
      contend(fw, nq);
      chk("arb2_first_is_read", 32'(fw), 32'd0);
      chk("arb2_req_count", 32'(nq), 32'd2);

      // Reset while a read is waiting for its ack
      ack_mode = 2;
      seen = 0;
      guard = 0;
      @(negedge up_clk);
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = 16'h0030;
      s_axi_rready  = 1'b1;
      while (!up_rreq && guard < 20) begin
         @(negedge up_clk);
         guard++;
         if (!s_axi_arready) s_axi_arvalid = 1'b0;
      end
      chk("rst_abort_req_seen", 32'(up_rreq), 32'd1);
      up_rstn = 1'b0;
      #1;
      chk("abort_rreq",   32'(up_rreq),      32'd0);
      chk("abort_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("abort_readys", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
      chk("abort_raddr",  32'(up_raddr),     32'd0);
      chk("abort_waddr",  32'(up_waddr),     32'd0);
      chk("abort_wdata",  up_wdata,          32'd0);
      chk("abort_rdata",  s_axi_rdata,       32'd0);
      chk("abort_resps",  32'({s_axi_bresp, s_axi_rresp}), 32'd0);
      s_axi_arvalid = 1'b0;
      repeat (2) @(negedge up_clk);
      up_rstn = 1'b1;
      @(negedge up_clk);
      chk("abort_arready_after", 32'(s_axi_arready), 32'd1);
      for (int k = 0; k < 30; k++) begin
         @(negedge up_clk);
         if (s_axi_rvalid || up_rreq || s_axi_bvalid) seen++;
      end
      chk("abort_no_response", 32'(seen), 32'd0);
      s_axi_rready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
